// File: rtl/act_out_rx_packer_if.sv
// Bundles the byte-receive, flush and pipe-out read signals of the
// activation output packer. The master modport drives the inputs, and the
// packer itself connects through the slave modport.
interface act_out_rx_packer_if #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned FIFO_AW    = $clog2(FIFO_DEPTH)
);

   // Controller / SPI side
   logic                act_out_rx_stage;
   logic [7:0]          rx_byte;
   logic                rx_byte_valid;
   logic                act_out_rx_done;
   logic                act_out_rx_valid;

   // Host pipe-out side
   logic                pipe_rd_en;
   logic                ovf_clr;
   logic [31:0]         pipe_dout;
   logic                fifo_empty;
   logic                fifo_full;
   logic [FIFO_AW:0]    word_count;
   logic [1:0]          byte_lane;
   logic                overflow;

   modport master (
      output act_out_rx_stage,
      output rx_byte,
      output rx_byte_valid,
      output act_out_rx_done,
      output pipe_rd_en,
      output ovf_clr,
      input  act_out_rx_valid,
      input  pipe_dout,
      input  fifo_empty,
      input  fifo_full,
      input  word_count,
      input  byte_lane,
      input  overflow
   );

   modport slave (
      input  act_out_rx_stage,
      input  rx_byte,
      input  rx_byte_valid,
      input  act_out_rx_done,
      input  pipe_rd_en,
      input  ovf_clr,
      output act_out_rx_valid,
      output pipe_dout,
      output fifo_empty,
      output fifo_full,
      output word_count,
      output byte_lane,
      output overflow
   );

endinterface

// File: rtl/act_out_rx_packer.sv
// Packs output-activation bytes received during the RX stage into 32-bit
// little-endian words and buffers them in a circular FIFO for the host
// pipe-out. A flush request pushes any partial word, zero-padded in its
// upper lanes. Words pushed while the FIFO is full (and not being read
// in the same cycle) are dropped and flagged in a sticky overflow bit.
module act_out_rx_packer #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned FIFO_AW    = $clog2(FIFO_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   act_out_rx_packer_if.slave       io_bus
);

   localparam logic [FIFO_AW:0] DepthCount = (FIFO_AW + 1)'(FIFO_DEPTH);
   localparam logic [FIFO_AW:0] CountOne   = (FIFO_AW + 1)'(1);

   // Packing state
   logic [31:0]         r_pack;
   logic [1:0]          r_lane;
   logic                r_tick;

   // FIFO state
   logic [31:0]         r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]  r_wptr;
   logic [FIFO_AW-1:0]  r_rptr;
   logic [FIFO_AW:0]    r_count;
   logic [31:0]         r_dout;
   logic                r_overflow;

   // Combinational
   logic                w_accept;
   logic [31:0]         w_merged;
   logic                w_push;
   logic [31:0]         w_push_word;
   logic [31:0]         w_pack_d;
   logic [1:0]          w_lane_d;
   logic                w_empty;
   logic                w_full;
   logic                w_rd;
   logic                w_wr;
   logic                w_drop;

   assign w_accept = io_bus.rx_byte_valid & io_bus.act_out_rx_stage;
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == DepthCount);

   // Pack register with the incoming byte dropped into its lane; upper lanes
   // are always zero in r_pack, so OR-ing is enough.
   assign w_merged = r_pack | ({24'h0, io_bus.rx_byte} << {r_lane, 3'b000});

   // Push decision and next packing state; a byte is merged before a flush.
   always_comb begin
      w_push      = 1'b0;
      w_push_word = r_pack;
      w_pack_d    = r_pack;
      w_lane_d    = r_lane;
      if (w_accept) begin
         w_push_word = w_merged;
         if (r_lane == 2'd3 || io_bus.act_out_rx_done) begin
            w_push   = 1'b1;
            w_pack_d = '0;
            w_lane_d = 2'd0;
         end else begin
            w_pack_d = w_merged;
            w_lane_d = r_lane + 2'd1;
         end
      end else if (io_bus.act_out_rx_done && r_lane != 2'd0) begin
         w_push   = 1'b1;
         w_pack_d = '0;
         w_lane_d = 2'd0;
      end
   end

   // FIFO access qualification; a full FIFO still accepts a push when it is
   // being read on the same edge.
   assign w_rd   = io_bus.pipe_rd_en & ~w_empty;
   assign w_wr   = w_push & (~w_full | w_rd);
   assign w_drop = w_push & w_full & ~w_rd;

   // Packing registers and the per-byte tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pack <= '0;
         r_lane <= 2'd0;
         r_tick <= 1'b0;
      end else begin
         r_pack <= w_pack_d;
         r_lane <= w_lane_d;
         r_tick <= w_accept;
      end
   end

   // FIFO storage; contents need no reset since occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= w_push_word;
      end
   end

   // FIFO pointers, occupancy, registered read data and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_dout     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd) begin
            r_rptr <= r_rptr + 1'b1;
            r_dout <= r_mem[r_rptr];
         end
         unique case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CountOne;
            2'b01:   r_count <= r_count - CountOne;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (io_bus.ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign io_bus.act_out_rx_valid = r_tick;
   assign io_bus.pipe_dout        = r_dout;
   assign io_bus.fifo_empty       = w_empty;
   assign io_bus.fifo_full        = w_full;
   assign io_bus.word_count       = r_count;
   assign io_bus.byte_lane        = r_lane;
   assign io_bus.overflow         = r_overflow;

endmodule
